// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the shared-memory arbiter.
package mem_arb_pkg;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Which requester currently owns the memory port.
    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } grant_e;

    localparam int TIMEOUT_DEFAULT = 255;

    // Width of a counter that must be able to hold the value TIMEOUT.
    function automatic int timeout_cnt_w(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mem_arb_timeout.sv
// Clearable up-counter that flags when the arbiter has waited TIMEOUT
// BUSY cycles without a memory acknowledge.
module mem_arb_timeout
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CNT_W   = timeout_cnt_w(TIMEOUT)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Terminal count is reached on the TIMEOUT-th enabled cycle after a clear.
    assign tc_o = (cnt_q == TC_VAL);

    // Next count: clear wins, otherwise count up and park at terminal count.
    always_comb begin
        // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer for the single backing memory shared by instruction
// fetch (if) and MEM-stage data access (dm). Define MEM_ARB_RR_EN for
// round-robin arbitration on contention; otherwise dm has fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ready_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ready_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_o,
    output logic              err_o,
    output logic [31:0]       stall_cnt_o
);

    state_e            state_q;
    grant_e            gnt_q;
    grant_e            gnt_d;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic              if_ready_q;
    logic              dm_ready_q;
    logic              err_q;
    logic [31:0]       stall_cnt_q;
    logic [31:0]       stall_cnt_d;
    logic              any_req;
    logic              grant_fire;
    logic              busy_tc;

`ifdef MEM_ARB_RR_EN
    grant_e            last_grant_q;
`endif

    assign if_rdata_o  = if_rdata_q;
    assign if_ready_o  = if_ready_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign dm_ready_o  = dm_ready_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign err_o       = err_q;
    assign stall_cnt_o = stall_cnt_q;

    // A requester stalls the pipeline until its completion cycle.
    assign stall_o = (if_req_i & ~if_ready_q) | (dm_req_i & ~dm_ready_q);

    // Pick the winner among the current requests.
    always_comb begin
        any_req = if_req_i | dm_req_i;
        gnt_d   = GNT_DM;
`ifdef MEM_ARB_RR_EN
        if (if_req_i && dm_req_i) begin
            gnt_d = (last_grant_q == GNT_DM) ? GNT_IF : GNT_DM;
        end else if (if_req_i) begin
            gnt_d = GNT_IF;
        end
`else
        if (if_req_i && !dm_req_i) begin
            gnt_d = GNT_IF;
        end
`endif
    end

    assign grant_fire = (state_q == IDLE) && start_i && any_req;

    // Watchdog on the BUSY wait; restarted on every grant.
    mem_arb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (grant_fire),
        .en_i  (state_q == BUSY),
        .tc_o  (busy_tc)
    );

`ifdef MEM_ARB_RR_EN
    // Remember the last winner so the other side wins the next contention.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant_q <= GNT_DM;
        end else if (grant_fire) begin
            last_grant_q <= gnt_d;
        end
    end
`endif

    // Main sequencer: grant, hold the memory request until ack or timeout,
    // then pulse the winner's ready for one cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            gnt_q       <= GNT_DM;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if_ready_q <= 1'b0;
            dm_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_fire) begin
                        gnt_q     <= gnt_d;
                        mem_req_q <= 1'b1;
                        state_q   <= BUSY;
                        if (gnt_d == GNT_DM) begin
                            mem_we_q    <= dm_we_i;
                            mem_addr_q  <= dm_addr_i;
                            mem_wdata_q <= dm_wdata_i;
                        end else begin
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= if_addr_i;
                            mem_wdata_q <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack_i) begin
                        mem_req_q <= 1'b0;
                        state_q   <= DONE;
                        if (gnt_q == GNT_DM) begin
                            dm_ready_q <= 1'b1;
                            if (!mem_we_q) dm_rdata_q <= mem_rdata_i;
                        end else begin
                            if_ready_q <= 1'b1;
                            if (!mem_we_q) if_rdata_q <= mem_rdata_i;
                        end
                    end else if (busy_tc) begin
                        mem_req_q <= 1'b0;
                        err_q     <= 1'b1;
                        state_q   <= DONE;
                        if (gnt_q == GNT_DM) begin
                            dm_ready_q <= 1'b1;
                            dm_rdata_q <= '0;
                        end else begin
                            if_ready_q <= 1'b1;
                            if_rdata_q <= '0;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Saturating count of cycles the running CPU spends stalled.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_o && start_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (default fixed-priority build, TIMEOUT=8).
module tb_mem_arbiter;

    localparam int TO = 8;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_ready_o;
    logic        dm_req_i;
    logic        dm_we_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic [31:0] dm_rdata_o;
    logic        dm_ready_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        stall_o;
    logic        err_o;
    logic [31:0] stall_cnt_o;

    int n_err = 0;
    int n_chk = 0;

    mem_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TO)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_rdata_o  (if_rdata_o),
        .if_ready_o  (if_ready_o),
        .dm_req_i    (dm_req_i),
        .dm_we_i     (dm_we_i),
        .dm_addr_i   (dm_addr_i),
        .dm_wdata_i  (dm_wdata_i),
        .dm_rdata_o  (dm_rdata_o),
        .dm_ready_o  (dm_ready_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .stall_o     (stall_o),
        .err_o       (err_o),
        .stall_cnt_o (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive point of a cycle: just after the rising edge.
    task automatic adv();
        @(posedge clk_i);
        #1;
    endtask

    // Sample point of a cycle: the falling edge.
    task automatic smp();
        @(negedge clk_i);
    endtask

    // ---------------- table-driven single-access vectors ----------------
    typedef struct {
        string       name;
        logic        if_req;
        logic        dm_req;
        logic        dm_we;
        logic [31:0] if_addr;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        int          lat;
        logic [31:0] rdata;
        logic        exp_dm;
        logic        exp_we;
        logic [31:0] exp_addr;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    // ---------------- reference model state for the random phase ----------------
    logic [31:0] ref_mem[int];
    logic [31:0] bus_mem[int];

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
    endfunction

    function automatic logic [31:0] bus_rd(input logic [31:0] a);
        return bus_mem.exists(int'(a)) ? bus_mem[int'(a)] : init_val(a);
    endfunction

    bit          inflight, rdy_now, if_pend, dm_pend, grant_now, exp_stall;
    int          who, gwho, rdy_who, ack_wait;
    logic [31:0] exp_addr, exp_wdata, exp_if_rdata, exp_dm_rdata, exp_cnt;
    logic        exp_we;

    initial begin
        vecs[0] = '{"if_single",  1'b1, 1'b0, 1'b0, 32'h14 - 32'h4, 32'h0,  32'h0,    5, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h10, 32'hDEAD_BEEF};
        vecs[1] = '{"dm_read",    1'b0, 1'b1, 1'b0, 32'h0,  32'h40, 32'h0,    1, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h40, 32'hCAFE_F00D};
        vecs[2] = '{"dm_store",   1'b0, 1'b1, 1'b1, 32'h0,  32'h20, 32'h1234, 3, 32'h7777_7777, 1'b1, 1'b1, 32'h20, 32'hCAFE_F00D};
        vecs[3] = '{"both_read",  1'b1, 1'b1, 1'b0, 32'h14, 32'h44, 32'h0,    1, 32'h1111_2222, 1'b1, 1'b0, 32'h44, 32'h1111_2222};
        vecs[4] = '{"both_store", 1'b1, 1'b1, 1'b1, 32'h14, 32'h48, 32'hA5A5, 2, 32'h0000_0099, 1'b1, 1'b1, 32'h48, 32'h1111_2222};
        vecs[5] = '{"if_fast",    1'b1, 1'b0, 1'b0, 32'h18, 32'h0,  32'h0,    1, 32'h0BAD_C0DE, 1'b0, 1'b0, 32'h18, 32'h0BAD_C0DE};

        rst_i = 1'b1; start_i = 1'b0;
        if_req_i = 1'b0; if_addr_i = '0;
        dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0;
        mem_ack_i = 1'b0; mem_rdata_i = '0;

        // ---------------- reset state ----------------
        adv(); adv();
        smp();
        check("rst_mem_req", mem_req_o, 1'b0);
        check("rst_mem_bus", {mem_we_o, mem_addr_o, mem_wdata_o}, '0);
        check("rst_ready", {if_ready_o, dm_ready_o}, 2'b00);
        check("rst_rdata", {if_rdata_o, dm_rdata_o}, '0);
        check("rst_err", err_o, 1'b0);
        check("rst_stall_cnt", stall_cnt_o, 32'd0);
        check("rst_stall", stall_o, 1'b0);
        adv();
        rst_i = 1'b0;

        // ---------------- start_i low blocks grants and freezes the counter ----------------
        if_req_i = 1'b1; if_addr_i = 32'h8;
        for (int c = 0; c < 5; c++) begin
            smp();
            check("nostart_mem_req", mem_req_o, 1'b0);
            check("nostart_stall_cnt", stall_cnt_o, 32'd0);
            check("nostart_stall", stall_o, 1'b1);
            adv();
        end
        start_i = 1'b1;
        smp();
        check("start_edge_mem_req", mem_req_o, 1'b0);
        adv();
        mem_ack_i = 1'b1; mem_rdata_i = 32'h0000_0A0A;
        smp();
        check("start_grant_mem_req", mem_req_o, 1'b1);
        check("start_grant_addr", mem_addr_o, 32'h8);
        check("start_stall_cnt1", stall_cnt_o, 32'd1);
        adv();
        mem_ack_i = 1'b0;
        smp();
        check("start_if_ready", if_ready_o, 1'b1);
        check("start_if_rdata", if_rdata_o, 32'h0000_0A0A);
        check("start_stall_cnt2", stall_cnt_o, 32'd2);
        check("start_stall_done", stall_o, 1'b0);
        adv();
        if_req_i = 1'b0;
        smp();
        check("start_ready_pulse", if_ready_o, 1'b0);
        adv();

        // ---------------- table vectors ----------------
        for (int i = 0; i < 6; i++) begin
            if_req_i = vecs[i].if_req; if_addr_i = vecs[i].if_addr;
            dm_req_i = vecs[i].dm_req; dm_we_i = vecs[i].dm_we;
            dm_addr_i = vecs[i].dm_addr; dm_wdata_i = vecs[i].dm_wdata;
            for (int c = 0; c <= vecs[i].lat + 1; c++) begin
                mem_ack_i   = (c == vecs[i].lat);
                mem_rdata_i = (c == vecs[i].lat) ? vecs[i].rdata : 32'hFFFF_FFFF;
                smp();
                if (c == 0) begin
                    check({vecs[i].name, "_req0"}, mem_req_o, 1'b0);
                    check({vecs[i].name, "_stall0"}, stall_o, 1'b1);
                end else if (c <= vecs[i].lat) begin
                    check({vecs[i].name, "_busy_req"}, mem_req_o, 1'b1);
                    check({vecs[i].name, "_busy_addr"}, mem_addr_o, vecs[i].exp_addr);
                    check({vecs[i].name, "_busy_we"}, mem_we_o, vecs[i].exp_we);
                    if (vecs[i].exp_we) check({vecs[i].name, "_busy_wdata"}, mem_wdata_o, vecs[i].dm_wdata);
                    check({vecs[i].name, "_busy_ready"}, {if_ready_o, dm_ready_o}, 2'b00);
                    check({vecs[i].name, "_busy_stall"}, stall_o, 1'b1);
                end else begin
                    check({vecs[i].name, "_ready"}, {if_ready_o, dm_ready_o}, {~vecs[i].exp_dm, vecs[i].exp_dm});
                    check({vecs[i].name, "_done_req"}, mem_req_o, 1'b0);
                    check({vecs[i].name, "_rdata"}, vecs[i].exp_dm ? dm_rdata_o : if_rdata_o, vecs[i].exp_rdata);
                    check({vecs[i].name, "_done_stall"}, stall_o, vecs[i].if_req & vecs[i].dm_req);
                end
                adv();
            end
            if_req_i = 1'b0; dm_req_i = 1'b0; dm_we_i = 1'b0; mem_ack_i = 1'b0;
            smp();
            adv();
        end

        // ---------------- contention: dm then if, one IDLE cycle between ----------------
        if_req_i = 1'b1; if_addr_i = 32'h30;
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h60;
        smp(); check("cont_c0_req", mem_req_o, 1'b0); adv();
        mem_ack_i = 1'b1; mem_rdata_i = 32'h6060_6060;
        smp(); check("cont_c1_addr", mem_addr_o, 32'h60); adv();
        mem_ack_i = 1'b0;
        smp();
        check("cont_c2_ready", {if_ready_o, dm_ready_o}, 2'b01);
        check("cont_c2_dm_rdata", dm_rdata_o, 32'h6060_6060);
        adv();
        dm_req_i = 1'b0;
        smp(); check("cont_c3_idle", mem_req_o, 1'b0); adv();
        mem_ack_i = 1'b1; mem_rdata_i = 32'h3030_3030;
        smp();
        check("cont_c4_req", mem_req_o, 1'b1);
        check("cont_c4_addr", mem_addr_o, 32'h30);
        adv();
        mem_ack_i = 1'b0;
        smp();
        check("cont_c5_ready", {if_ready_o, dm_ready_o}, 2'b10);
        check("cont_c5_if_rdata", if_rdata_o, 32'h3030_3030);
        adv();
        if_req_i = 1'b0;
        smp(); adv();

        // ---------------- timeout with no ack ----------------
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h70;
        for (int c = 0; c <= TO + 1; c++) begin
            smp();
            if (c >= 1 && c <= TO) begin
                check("to_busy_req", mem_req_o, 1'b1);
                check("to_busy_ready", dm_ready_o, 1'b0);
                check("to_busy_err", err_o, 1'b0);
            end else if (c == TO + 1) begin
                check("to_done_ready", dm_ready_o, 1'b1);
                check("to_done_rdata", dm_rdata_o, 32'h0);
                check("to_done_err", err_o, 1'b1);
                check("to_done_req", mem_req_o, 1'b0);
            end
            adv();
        end
        dm_req_i = 1'b0;
        smp(); check("to_after_ready", dm_ready_o, 1'b0); check("to_sticky1", err_o, 1'b1); adv();
        smp(); check("to_sticky2", err_o, 1'b1); adv();

        // ---------------- reset mid-access, then a stale ack ----------------
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h50;
        smp(); adv();
        smp(); check("rb_busy_req", mem_req_o, 1'b1); adv();
        rst_i = 1'b1; dm_req_i = 1'b0;
        smp(); check("rb_async_req", mem_req_o, 1'b0); check("rb_async_err", err_o, 1'b0); adv();
        rst_i = 1'b0;
        smp(); adv();
        mem_ack_i = 1'b1; mem_rdata_i = 32'h0000_BEEF;
        smp(); adv();
        mem_ack_i = 1'b0;
        smp();
        check("rb_ready", {if_ready_o, dm_ready_o}, 2'b00);
        check("rb_mem_bus", {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o}, '0);
        check("rb_rdata", {if_rdata_o, dm_rdata_o}, '0);
        check("rb_err", err_o, 1'b0);
        check("rb_stall_cnt", stall_cnt_o, 32'd0);
        check("rb_stall", stall_o, 1'b0);
        adv();

        // ---------------- randomized traffic against a transaction-level model ----------------
        inflight = 1'b0; rdy_now = 1'b0; if_pend = 1'b0; dm_pend = 1'b0;
        who = 0; rdy_who = 0; ack_wait = 0;
        exp_addr = '0; exp_we = 1'b0; exp_wdata = '0;
        exp_if_rdata = '0; exp_dm_rdata = '0; exp_cnt = '0;
        for (int n = 0; n < 1500; n++) begin
            // Requesters: issue a new request only once the previous one has completed.
            if (!if_pend && $urandom_range(0, 9) < 4) begin
                if_pend   = 1'b1;
                if_addr_i = 32'($urandom_range(0, 7) * 4);
            end
            if (!dm_pend && $urandom_range(0, 9) < 4) begin
                dm_pend    = 1'b1;
                dm_we_i    = 1'($urandom_range(0, 1));
                dm_addr_i  = 32'($urandom_range(0, 7) * 4);
                dm_wdata_i = $urandom;
            end
            if_req_i = if_pend;
            dm_req_i = dm_pend;
            start_i  = ($urandom_range(0, 9) != 0);

            // Memory: ack after the chosen latency; occasionally a stray ack when idle.
            if (inflight && ack_wait == 0) begin
                mem_ack_i = 1'b1;
                if (mem_we_o) begin
                    bus_mem[int'(mem_addr_o)] = mem_wdata_o;
                    mem_rdata_i = $urandom;
                end else begin
                    mem_rdata_i = bus_rd(mem_addr_o);
                end
            end else begin
                mem_ack_i   = !inflight && ($urandom_range(0, 7) == 0);
                mem_rdata_i = $urandom;
            end

            grant_now = !inflight && !rdy_now && start_i && (if_pend || dm_pend);
            gwho      = dm_pend ? 1 : 0;

            smp();
            if (rdy_now) begin
                if (rdy_who == 0) exp_if_rdata = ref_rd(if_addr_i);
                else if (!dm_we_i) exp_dm_rdata = ref_rd(dm_addr_i);
                else ref_mem[int'(dm_addr_i)] = dm_wdata_i;
            end
            exp_stall = (if_pend && !(rdy_now && rdy_who == 0)) ||
                        (dm_pend && !(rdy_now && rdy_who == 1));
            check("rnd_mem_req", mem_req_o, inflight);
            if (inflight) begin
                check("rnd_mem_addr", mem_addr_o, exp_addr);
                check("rnd_mem_we", mem_we_o, exp_we);
                if (exp_we) check("rnd_mem_wdata", mem_wdata_o, exp_wdata);
            end
            check("rnd_if_ready", if_ready_o, rdy_now && rdy_who == 0);
            check("rnd_dm_ready", dm_ready_o, rdy_now && rdy_who == 1);
            check("rnd_if_rdata", if_rdata_o, exp_if_rdata);
            check("rnd_dm_rdata", dm_rdata_o, exp_dm_rdata);
            check("rnd_stall", stall_o, exp_stall);
            check("rnd_stall_cnt", stall_cnt_o, exp_cnt);
            check("rnd_err", err_o, 1'b0);

            // Advance the model to the next cycle.
            if (exp_stall && start_i && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
            if (rdy_now) begin
                if (rdy_who == 0) if_pend = 1'b0;
                else dm_pend = 1'b0;
                rdy_now = 1'b0;
            end else if (inflight) begin
                if (ack_wait == 0) begin
                    inflight = 1'b0;
                    rdy_now  = 1'b1;
                    rdy_who  = who;
                end else begin
                    ack_wait--;
                end
            end else if (grant_now) begin
                inflight  = 1'b1;
                who       = gwho;
                ack_wait  = $urandom_range(0, 3);
                exp_addr  = (gwho == 1) ? dm_addr_i : if_addr_i;
                exp_we    = (gwho == 1) ? dm_we_i : 1'b0;
                exp_wdata = dm_wdata_i;
            end
            adv();
        end

        if_req_i = 1'b0; dm_req_i = 1'b0; mem_ack_i = 1'b0;
        repeat (3) adv();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter and sequencer for a single shared backing memory used by both the instruction-fetch stage and the MEM-stage data access of the 5-stage pipelined CPU. Replaces the separate single-cycle instruction and data memories. Grants one requester at a time, runs a req/ack handshake to the memory, and returns read data with a one-cycle ready pulse. Drives the pipeline-wide stall while any request is outstanding.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, max cycles waiting for mem_ack_i before abort (≥1)

- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  CPU run enable; no new grants while low
- if_req_i  in  1  fetch request, held until if_ready_o
- if_addr_i  in  ADDR_W  fetch address
- if_rdata_o  out  DATA_W  fetched instruction, registered
- if_ready_o  out  1  one-cycle completion pulse
- dm_req_i  in  1  data request, held until dm_ready_o
- dm_we_i  in  1  1 = write, 0 = read
- dm_addr_i  in  ADDR_W  data address
- dm_wdata_i  in  DATA_W  write data
- dm_rdata_o  out  DATA_W  load data, registered
- dm_ready_o  out  1  one-cycle completion pulse
- mem_req_o  out  1  memory request, held until ack
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_ack_i  in  1  single-cycle memory completion
- mem_rdata_i  in  DATA_W  memory read data, valid with mem_ack_i
- stall_o  out  1  pipeline stall, combinational
- err_o  out  1  sticky timeout flag
- stall_cnt_o  out  32  saturating stall-cycle counter

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: if start_i=1 and any request, grant and latch the granted requester's address/we/wdata into mem_*_o, set mem_req_o=1, go to BUSY. No request or start_i=0: stay.
- Contention: dm wins, because the MEM-stage instruction is older.
- BUSY: mem_req_o and mem_*_o are held constant. On mem_ack_i=1:
  - Drop mem_req_o.
  - On a read, capture mem_rdata_i into the granted rdata register. On a write, rdata is unchanged.
  - Go to DONE.
- BUSY timeout counter is cleared on BUSY entry. If TIMEOUT cycles pass without ack: set err_o, load rdata with 0, drop mem_req_o, go to DONE.
- DONE: granted ready_o=1 for exactly this cycle. Go to IDLE unconditionally. Requests are not evaluated in DONE.
- stall_o = (if_req_i & ~if_ready_o) | (dm_req_i & ~dm_ready_o).
- stall_cnt_o increments when stall_o & start_i, and saturates at 0xFFFF_FFFF.
- mem_ack_i outside BUSY is ignored.
- Reset values: all outputs 0, state IDLE, err_o 0, stall_cnt_o 0. Reset mid-access aborts it, and a later stale ack is ignored.

## Timing
- Request seen in IDLE at cycle 0 → mem_req_o=1 at cycle 1.
- Ack at cycle k (k≥1) → ready and rdata valid at cycle k+1 → IDLE at cycle k+2.
- Minimum turnaround is 3 cycles per access. Back-to-back accesses have one IDLE cycle between them.
- rdata_o holds its value until the next completion for that requester.
- Requester must keep req/addr/we/wdata stable from assertion through its ready cycle. The pipeline advances on the edge ending the ready cycle.
- err_o rises in the DONE cycle of the timed-out access and clears only on reset.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration. A last_grant flop (reset value: dm) is updated on each grant. On contention the requester not last granted wins.
- MEM_ARB_RR_EN undefined: fixed priority, dm over if. No last_grant flop.
- Uncontended grants are identical in both builds.

## Structure
- Package mem_arb_pkg holds:
  - state enum {IDLE, BUSY, DONE}
  - grant enum {GNT_IF, GNT_DM}
  - TIMEOUT counter width as $clog2(TIMEOUT+1)
- One sub-module, mem_arb_timeout: clearable counter with a terminal-count output, used by BUSY.
- Everything else lives in mem_arbiter.

## Test plan
- Single fetch: if_req_i=1, addr 0x10, ack 4 cycles after mem_req_o, rdata 0xDEADBEEF → if_ready_o pulse at cycle 6, if_rdata_o=0xDEADBEEF, stall_o=1 during cycles 0–5.
- Simultaneous requests: if and dm at cycle 0, ack latency 1 → dm served first, if served second. With MEM_ARB_RR_EN, a repeat contention alternates the winner.
- Store: dm_we_i=1, addr 0x20, wdata 0x1234 → mem_we_o=1, mem_addr_o=0x20, mem_wdata_o=0x1234 held until ack; dm_rdata_o unchanged.
- Timeout with TIMEOUT=8 and no ack → dm_ready_o pulse after 8 BUSY cycles, dm_rdata_o=0, err_o=1 stays high.
- Reset during BUSY, then ack one cycle after reset release → no ready pulse, state IDLE, all outputs 0.
- start_i=0 with if_req_i=1 → no mem_req_o and stall_cnt_o frozen. Raising start_i resumes the grant next cycle.
